i2c_request_arbiter: RTL
========================

Name: i2c_request_arbiter

Overview:
- Shares the single I2C master FSM between NREQ requesters, e.g. a sensor poller, the AXI software path and a boot-time configuration loader.
- Round-robin arbitration; latches the winner's transaction descriptor and drives the master's control fields (address, register, read/write, byte count, use-register, start).
- Tracks master busy/ack status and returns a done/error completion pulse to the owning requester.
- Sits between the AXI register block and the I2C FSM, all on axi_clk.

Parameters:
- NREQ, 3, number of requesters (2..8)
- GRANT_W, $clog2(NREQ), width of the grant index
- START_HOLD_MAX, 1000, maximum axi_clk cycles start is held waiting for the master's clear_start_request

Ports:
- axi_clk  in  1  system clock (100 MHz)
- axi_resetn  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester transaction request, level, held until done
- req_addr  in  NREQ*7  7-bit device address per requester
- req_reg  in  NREQ*8  register address per requester
- req_rw  in  NREQ  1=read, 0=write
- req_bytes  in  NREQ*4  byte count per requester (1..15)
- req_use_reg  in  NREQ  register phase enable
- done  out  NREQ  one-cycle completion pulse to the owner
- error  out  NREQ  one-cycle pulse with done: NACK or start timeout
- grant_valid  out  1  a requester currently owns the master
- grant_idx  out  GRANT_W  owner index, valid while grant_valid
- m_address  out  32  to master address_reg, bits[6:0] used, rest 0
- m_register  out  32  to master register_reg, bits[7:0] used, rest 0
- m_read_write  out  1  to master control
- m_byte_count  out  4  to master control
- m_use_register  out  1  to master control
- m_start  out  1  to master start
- m_clear_start  in  1  master's start acknowledge
- m_busy  in  1  master status_reg[7]
- m_ack_error  in  1  master NACK flag

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, rr_ptr=0, all outputs 0.
- States: IDLE, LAUNCH, WAIT_BUSY, RUN, COMPLETE.
- IDLE:
  - Scan req starting at rr_ptr, wrapping modulo NREQ; first set bit wins.
  - Descriptor is latched into m_* registers, grant_idx is set and grant_valid=1; next state LAUNCH.
  - req_bytes==0 is treated as 1.
  - Arbitration takes 1 cycle (req seen at cycle N, m_start high at N+1).
- LAUNCH:
  - m_start=1 and the start_hold counter increments.
  - On m_clear_start=1: drop m_start the next cycle and go to WAIT_BUSY.
  - If the counter reaches START_HOLD_MAX: go to COMPLETE with error.
- WAIT_BUSY: wait for m_busy=1, then go to RUN. m_busy already high on entry is accepted immediately.
- RUN:
  - On m_busy falling (registered m_busy 1→0), sample m_ack_error and go to COMPLETE.
  - If m_ack_error rises while m_busy is still 1, it is latched as sticky.
- COMPLETE:
  - Pulse done[grant_idx] for 1 cycle; error[grant_idx] is pulsed when a NACK or timeout occurred.
  - Set rr_ptr=(grant_idx+1) mod NREQ, clear grant_valid, go to IDLE.
- Minimum gap between transactions: 1 IDLE cycle.
- m_* fields stay stable from LAUNCH through COMPLETE; requester input changes are ignored after the latch.
- A requester that drops req mid-transaction does not abort the transfer; the done pulse is still emitted.
- Simultaneous requests are resolved by rr_ptr only; no requester wins twice while another is pending.
- Reset mid-transaction: m_start=0 immediately; no done pulse is emitted.

Optional Feature:
- Macro: I2C_ARB_WATCHDOG_EN.
- Defined:
  - Adds parameter RUN_TIMEOUT (default 2_000_000 cycles).
  - A RUN-state counter forces COMPLETE with error and sets a sticky output wdog_fired (1 bit), cleared only by reset.
- Undefined: RUN waits indefinitely for m_busy to fall; wdog_fired is absent.

Decomposition:
- Package i2c_arb_pkg:
  - state enum arb_state_t.
  - struct i2c_desc_t {addr[6:0], reg_addr[7:0], rw, bytes[3:0], use_reg}.
  - Constants BUSY_BIT=7 and MAX_BYTES=15.
- One sub-module: i2c_rr_picker, a combinational round-robin priority encoder with inputs req and rr_ptr and outputs found and idx.

Test Plan:
- Single write: req[0]=1, addr=0x50, reg=0x10, bytes=2, rw=0; model master returns clear_start after 3 cycles, busy for 200 cycles, ack_error=0 -> m_start high for exactly 4 cycles, done[0] pulses once with error[0]=0, grant_valid=0 one cycle later.
- Round-robin: req=3'b111 held, rr_ptr=0 -> grant order 0,1,2,0; no done on any non-owner.
- NACK: master sets ack_error=1 and drops busy -> done[1] and error[1] both pulse on the same cycle; next grant proceeds normally.
- Start timeout: m_clear_start never asserted, START_HOLD_MAX=8 -> m_start drops after 8 cycles; done and error pulse; busy is never awaited.
- Requester drop: req[2] cleared in RUN -> transfer completes, done[2] still pulses, m_* stable throughout.
- Reset mid-RUN: axi_resetn low during RUN -> all outputs 0 asynchronously, rr_ptr=0, no done after release.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C request arbiter.
// Covers the FSM state encoding, the latched transaction descriptor and byte-count normalisation.
package i2c_arb_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_BUSY = 3'd2,
      RUN       = 3'd3,
      COMPLETE  = 3'd4
   } arb_state_t;

   typedef struct packed {
      logic [6:0] addr;
      logic [7:0] reg_addr;
      logic       rw;
      logic [3:0] bytes;
      logic       use_reg;
   } i2c_desc_t;

   localparam int BUSY_BIT  = 7;
   localparam int MAX_BYTES = 15;

   // A zero byte count would stall the master, so it is promoted to a single byte.
   function automatic logic [3:0] norm_bytes(input logic [3:0] b);
      return (b == 4'd0) ? 4'd1 : b;
   endfunction

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin priority encoder.
// The first set request at or after rr_ptr wins, wrapping modulo NREQ.
module i2c_rr_picker #(
   parameter int NREQ    = 3,
   parameter int GRANT_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]    req,
   input  logic [GRANT_W-1:0] rr_ptr,
   output logic               found,
   output logic [GRANT_W-1:0] idx
);

   logic [GRANT_W-1:0] pos [NREQ];
   logic [NREQ-1:0]    hit;

   genvar gi;
   for (gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [GRANT_W:0] sum;
      assign sum     = {1'b0, rr_ptr} + (GRANT_W+1)'(gi);
      assign pos[gi] = (sum >= (GRANT_W+1)'(NREQ)) ? GRANT_W'(sum - (GRANT_W+1)'(NREQ))
                                                   : sum[GRANT_W-1:0];
      assign hit[gi] = req[pos[gi]];
   end

   // Walk from the far end so the smallest offset from rr_ptr is written last.
   always_comb begin
      found = |hit;
      idx   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (hit[i]) begin
            idx = pos[i];
         end
      end
   end

endmodule

// File: rtl/i2c_request_arbiter.sv
// Round-robin owner of the single I2C master FSM: latches the winning descriptor,
// runs start/busy handshakes and pulses done/error back. Optional RUN watchdog: I2C_ARB_WATCHDOG_EN.
module i2c_request_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NREQ           = 3,
   parameter int GRANT_W        = $clog2(NREQ),
   parameter int START_HOLD_MAX = 1000
`ifdef I2C_ARB_WATCHDOG_EN
   ,
   parameter int RUN_TIMEOUT    = 2_000_000
`endif
) (
   input  logic                 axi_clk,
   input  logic                 axi_resetn,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*7-1:0]    req_addr,
   input  logic [NREQ*8-1:0]    req_reg,
   input  logic [NREQ-1:0]      req_rw,
   input  logic [NREQ*4-1:0]    req_bytes,
   input  logic [NREQ-1:0]      req_use_reg,
   output logic [NREQ-1:0]      done,
   output logic [NREQ-1:0]      error,
   output logic                 grant_valid,
   output logic [GRANT_W-1:0]   grant_idx,
   output logic [31:0]          m_address,
   output logic [31:0]          m_register,
   output logic                 m_read_write,
   output logic [3:0]           m_byte_count,
   output logic                 m_use_register,
   output logic                 m_start,
   input  logic                 m_clear_start,
   input  logic                 m_busy,
   input  logic                 m_ack_error
`ifdef I2C_ARB_WATCHDOG_EN
   ,
   output logic                 wdog_fired
`endif
);

   localparam int HOLD_W = $clog2(START_HOLD_MAX + 1);

   arb_state_t          state_q, state_d;
   logic [GRANT_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [GRANT_W-1:0]  grant_idx_q, grant_idx_d;
   logic                grant_valid_q, grant_valid_d;
   i2c_desc_t           desc_q, desc_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic                busy_q;
   logic                nack_q, nack_d;
   logic                err_q, err_d;

   logic                pick_found;
   logic [GRANT_W-1:0]  pick_idx;
   i2c_desc_t           req_desc [NREQ];
   logic                done_any;

`ifdef I2C_ARB_WATCHDOG_EN
   localparam int RUN_W = $clog2(RUN_TIMEOUT + 1);
   logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
   logic                wdog_q, wdog_d;
`endif

   i2c_rr_picker #(
      .NREQ    (NREQ),
      .GRANT_W (GRANT_W)
   ) u_picker (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .found  (pick_found),
      .idx    (pick_idx)
   );

   assign done_any = (state_q == COMPLETE);

   genvar gi;
   for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_desc[gi] = '{
         addr:     req_addr[gi*7 +: 7],
         reg_addr: req_reg[gi*8 +: 8],
         rw:       req_rw[gi],
         bytes:    norm_bytes(req_bytes[gi*4 +: 4]),
         use_reg:  req_use_reg[gi]
      };
      assign done[gi]  = done_any && (grant_idx_q == GRANT_W'(gi));
      assign error[gi] = done[gi] && err_q;
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      desc_d        = desc_q;
      hold_cnt_d    = hold_cnt_q;
      nack_d        = nack_q;
      err_d         = err_q;
`ifdef I2C_ARB_WATCHDOG_EN
      run_cnt_d     = '0;
      wdog_d        = wdog_q;
`endif

      case (state_q)
         IDLE: begin
            hold_cnt_d = '0;
            nack_d     = 1'b0;
            err_d      = 1'b0;
            if (pick_found) begin
               desc_d        = req_desc[pick_idx];
               grant_idx_d   = pick_idx;
               grant_valid_d = 1'b1;
               state_d       = LAUNCH;
            end
         end

         // An acknowledge in the final hold cycle still counts as a successful launch.
         LAUNCH: begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (m_clear_start) begin
               state_d = WAIT_BUSY;
            end else if (hold_cnt_d == HOLD_W'(START_HOLD_MAX)) begin
               err_d   = 1'b1;
               state_d = COMPLETE;
            end
         end

         WAIT_BUSY: begin
            if (m_busy) begin
               state_d = RUN;
            end
         end

         RUN: begin
`ifdef I2C_ARB_WATCHDOG_EN
            run_cnt_d = run_cnt_q + 1'b1;
`endif
            if (busy_q && !m_busy) begin
               err_d   = nack_q | m_ack_error;
               state_d = COMPLETE;
`ifdef I2C_ARB_WATCHDOG_EN
            end else if (run_cnt_d == RUN_W'(RUN_TIMEOUT)) begin
               err_d   = 1'b1;
               wdog_d  = 1'b1;
               state_d = COMPLETE;
`endif
            end else if (m_busy && m_ack_error) begin
               nack_d = 1'b1;
            end
         end

         COMPLETE: begin
            rr_ptr_d      = (grant_idx_q == GRANT_W'(NREQ - 1)) ? '0 : grant_idx_q + 1'b1;
            grant_valid_d = 1'b0;
            state_d       = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         desc_q        <= '0;
         hold_cnt_q    <= '0;
         busy_q        <= 1'b0;
         nack_q        <= 1'b0;
         err_q         <= 1'b0;
`ifdef I2C_ARB_WATCHDOG_EN
         run_cnt_q     <= '0;
         wdog_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
         desc_q        <= desc_d;
         hold_cnt_q    <= hold_cnt_d;
         busy_q        <= m_busy;
         nack_q        <= nack_d;
         err_q         <= err_d;
`ifdef I2C_ARB_WATCHDOG_EN
         run_cnt_q     <= run_cnt_d;
         wdog_q        <= wdog_d;
`endif
      end
   end

   // Outputs decode straight from flops so the async reset clears them at once.
   assign grant_valid    = grant_valid_q;
   assign grant_idx      = grant_idx_q;
   assign m_start        = (state_q == LAUNCH);
   assign m_address      = {25'd0, desc_q.addr};
   assign m_register     = {24'd0, desc_q.reg_addr};
   assign m_read_write   = desc_q.rw;
   assign m_byte_count   = desc_q.bytes;
   assign m_use_register = desc_q.use_reg;
`ifdef I2C_ARB_WATCHDOG_EN
   assign wdog_fired     = wdog_q;
`endif

endmodule
